aes_key_expansion_ctrl: RTL and testbench
=========================================

Name: aes_key_expansion_ctrl

Overview:
- Sequential AES-128 key-schedule controller. It expands a 128-bit cipher key into round keys 0..10, one round at a time, and hands each round key to the round datapath over a valid/ready handshake.
- Owns exactly one instance of the team's combinational 8-bit AES S-box and time-multiplexes it over the four SubWord bytes of every round, trading latency for area.

Parameters:
- NR, 10, number of expansion rounds; only 10 (AES-128) is supported, and any other value is a synthesis error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin an expansion; sampled only in IDLE
- key_in  input  128  cipher key; byte 0 at [127:120], w0 = [127:96]
- rk_ready  input  1  consumer accepts round_key this cycle
- round_key  output  128  current round key (w4r..w4r+3), same byte order as key_in
- rk_valid  output  1  round_key/round_idx valid; held until accepted
- round_idx  output  4  round number 0..10 of round_key
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse after round 10 is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, round_key=0, rk_valid=0, round_idx=0, busy=0, done=0, byte counter=0, sub_word=0, rcon=8'h01. Reset mid-expansion aborts it immediately; no partial keys are produced afterwards.
- States: IDLE, WAIT, SUB, CALC.
- IDLE:
  - Sampling start=1 at edge E0 sets round_key<=key_in, round_idx<=0, rk_valid<=1, busy<=1, rcon<=01, and moves to WAIT.
  - start=0 stays in IDLE.
- WAIT: holds rk_valid=1 with round_key/round_idx stable. On rk_valid&rk_ready:
  - rk_valid<=0.
  - If round_idx==10: go to IDLE, busy<=0, done<=1 for one cycle.
  - Otherwise go to SUB with cnt<=0.
- SUB (4 cycles, cnt 0..3):
  - S-box input = byte cnt of RotWord(w3), i.e. w3 bytes 1,2,3,0 for cnt=0..3.
  - At each edge, the S-box output is registered into sub_word byte cnt.
  - cnt==3 goes to CALC.
- CALC (1 cycle):
  - t = sub_word ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - Writes round_key, round_idx<=round_idx+1, rk_valid<=1, rcon<=xtime(rcon), where xtime = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0).
  - Goes to WAIT.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Latency with rk_ready tied high: round 0 is valid the cycle after E0; each later round follows 6 cycles after the previous one (1 WAIT + 4 SUB + 1 CALC). Round 10 is valid at E0+60, and done pulses at E0+61.
- Backpressure: every WAIT cycle with rk_ready=0 delays all later rounds by one cycle. Outputs must not change while rk_valid=1 and rk_ready=0.
- start while busy=1 is ignored, including start arriving in the same cycle as the done pulse. start is accepted from the cycle after done.
- rk_ready while rk_valid=0 is ignored.
- The S-box is not used outside SUB; its input is driven to 0 outside SUB.

Test Plan:
- Single expansion with rk_ready=1, start with key 2b7e151628aed2a6abf7158809cf4f3c:
  - Round 0 equals the key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at E0+60.
  - done pulses once at E0+61.
- Backpressure: same key, rk_ready low for 7 cycles during round 3. round_key/round_idx=3 stay stable for the whole stall, and round 10 arrives at E0+67.
- start pulses during round 5 and in the done cycle are ignored, with no change to the sequence. A second start afterwards with key 000102030405060708090a0b0c0d0e0f yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset: rst_n=0 in the middle of a SUB cycle of round 4. All outputs go to 0 asynchronously, and a new start produces round 0 correctly.
- All-zero key: round 1 = 62636363626363636263636362636363, exercising the S-box(00)=63 lookup and Rcon 01.
- Rcon wrap: check rounds 9 and 10 of the 2b7e… key use Rcon 1b and 36.

Source files
------------

// File: rtl/aes_key_expansion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expansion_ctrl (with helper aes_sbox)
//  Description : Sequential AES-128 key schedule. Produces round keys 0..10
//                one at a time over a valid/ready handshake, sharing a single
//                8-bit S-box across the four SubWord bytes of each round.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  aes_sbox : combinational AES S-box (GF(2^8) inverse followed by the affine
//  transform). The inverse is a^254 built from a square-and-multiply chain.
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] w_inv;

    // Inverse then affine transform with constant 0x63
    always_comb begin
        w_inv    = gf_inv(sbox_in);
        sbox_out = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// ----------------------------------------------------------------------------
//  aes_key_expansion_ctrl : key-schedule controller
// ----------------------------------------------------------------------------
module aes_key_expansion_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic         rk_valid,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    // Only the 10-round AES-128 schedule is implemented
    if (NR != 10) begin : g_nr_unsupported
        $error("aes_key_expansion_ctrl: only NR=10 is supported");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SUB  = 2'd2,
        S_CALC = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_cnt;
    logic [31:0]  r_sub_word;
    logic [7:0]   r_rcon;

    logic         w_load;
    logic         w_accept;
    logic         w_last;
    logic [7:0]   w_sbox_in;
    logic [7:0]   w_sbox_out;
    logic [7:0]   w_rcon_nxt;
    logic [31:0]  w_t;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [127:0] w_next_key;

    // The only S-box instance; time-multiplexed over the four SubWord bytes
    aes_sbox u_sbox (
        .sbox_in  (w_sbox_in),
        .sbox_out (w_sbox_out)
    );

    // Handshake qualifiers; a start coinciding with done is deliberately dropped
    assign w_load   = (r_state == S_IDLE) && start && !done;
    assign w_accept = (r_state == S_WAIT) && rk_valid && rk_ready;
    assign w_last   = (round_idx == 4'd10);

    // S-box input: byte cnt of RotWord(w3) in SUB, zero otherwise
    always_comb begin
        w_sbox_in = 8'h00;
        if (r_state == S_SUB) begin
            case (r_cnt)
                2'd0:    w_sbox_in = round_key[23:16];
                2'd1:    w_sbox_in = round_key[15:8];
                2'd2:    w_sbox_in = round_key[7:0];
                default: w_sbox_in = round_key[31:24];
            endcase
        end
    end

    // Next round key from the completed SubWord and the current Rcon
    always_comb begin
        w_t        = r_sub_word ^ {r_rcon, 24'h000000};
        w_w0       = round_key[127:96] ^ w_t;
        w_w1       = round_key[95:64]  ^ w_w0;
        w_w2       = round_key[63:32]  ^ w_w1;
        w_w3       = round_key[31:0]   ^ w_w2;
        w_next_key = {w_w0, w_w1, w_w2, w_w3};
        w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_load)   w_state_nxt = S_WAIT;
            S_WAIT: if (w_accept) w_state_nxt = w_last ? S_IDLE : S_SUB;
            S_SUB:  if (r_cnt == 2'd3) w_state_nxt = S_CALC;
            S_CALC: w_state_nxt = S_WAIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_key  <= 128'h0;
            rk_valid   <= 1'b0;
            round_idx  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            r_cnt      <= 2'd0;
            r_sub_word <= 32'h0;
            r_rcon     <= 8'h01;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        round_key <= key_in;
                        round_idx <= 4'd0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        r_rcon    <= 8'h01;
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        rk_valid <= 1'b0;
                        if (w_last) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            r_cnt <= 2'd0;
                        end
                    end
                end
                S_SUB: begin
                    case (r_cnt)
                        2'd0:    r_sub_word[31:24] <= w_sbox_out;
                        2'd1:    r_sub_word[23:16] <= w_sbox_out;
                        2'd2:    r_sub_word[15:8]  <= w_sbox_out;
                        default: r_sub_word[7:0]   <= w_sbox_out;
                    endcase
                    r_cnt <= r_cnt + 2'd1;
                end
                default: begin
                    round_key <= w_next_key;
                    round_idx <= round_idx + 4'd1;
                    rk_valid  <= 1'b1;
                    r_rcon    <= w_rcon_nxt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expansion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expansion_ctrl
//  Description : Directed self-checking bench for aes_key_expansion_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_key_expansion_ctrl;

    localparam logic [127:0] C_K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] C_K1_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] C_K1_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] C_K1_R8  = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] C_K1_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] C_K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C_Z_R1   = 128'h62636363626363636263636362636363;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic [127:0] round_key;
    logic         rk_valid;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    logic [127:0] got_key [0:10];
    int           got_at  [0:10];
    int           done_at;
    int           done_cnt;
    bit           stall_ok;

    aes_key_expansion_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_valid  (rk_valid),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an expansion and records every round key with its edge offset
    // from the start edge. Optional stall of one round and stray start pulses.
    task automatic run_collect(input logic [127:0] key, input int stall_round,
                               input int stall_len, input bit inj5, input bit injdone);
        int n;
        int stall_left;
        for (int i = 0; i <= 10; i++) begin
            got_key[i] = '0;
            got_at[i]  = -1;
        end
        done_at    = -1;
        done_cnt   = 0;
        stall_ok   = 1'b1;
        stall_left = 0;
        @(negedge clk);
        key_in   = key;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = '1;
        n      = 0;
        while (n <= 200 && !(done_at >= 0 && n > done_at + 4)) begin
            start = 1'b0;
            if (rk_valid && round_idx <= 4'd10) begin
                if (got_at[round_idx] < 0) begin
                    got_key[round_idx] = round_key;
                    got_at[round_idx]  = n;
                    if (int'(round_idx) == stall_round) stall_left = stall_len;
                    if (inj5 && round_idx == 4'd5) start = 1'b1;
                end else if (round_key !== got_key[round_idx]) begin
                    stall_ok = 1'b0;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    if (injdone) start = 1'b1;
                end
            end
            if (stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end else begin
                rk_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (round_key !== 128'h0) begin errors++; $display("FAIL reset_round_key got %h exp 0", round_key); end
        checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid); end
        checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL reset_round_idx got %0d exp 0", round_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_start got valid=%b busy=%b exp 0 0", rk_valid, busy); end
    endtask

    task automatic test_single;
        run_collect(C_K1, -1, 0, 1'b0, 1'b0);
        checks++; if (got_key[0] !== C_K1) begin errors++; $display("FAIL single_r0 got %h exp %h", got_key[0], C_K1); end
        checks++; if (got_at[0] != 0) begin errors++; $display("FAIL single_r0_time got %0d exp 0", got_at[0]); end
        checks++; if (got_key[1] !== C_K1_R1) begin errors++; $display("FAIL single_r1 got %h exp %h", got_key[1], C_K1_R1); end
        checks++; if (got_at[1] != 6) begin errors++; $display("FAIL single_r1_time got %0d exp 6", got_at[1]); end
        checks++; if (got_key[2] !== C_K1_R2) begin errors++; $display("FAIL single_r2 got %h exp %h", got_key[2], C_K1_R2); end
        checks++; if (got_key[3] !== C_K1_R3) begin errors++; $display("FAIL single_r3 got %h exp %h", got_key[3], C_K1_R3); end
        checks++; if (got_key[10] !== C_K1_R10) begin errors++; $display("FAIL single_r10 got %h exp %h", got_key[10], C_K1_R10); end
        checks++; if (got_at[10] != 60) begin errors++; $display("FAIL single_r10_time got %0d exp 60", got_at[10]); end
        checks++; if (done_at != 61) begin errors++; $display("FAIL single_done_time got %0d exp 61", done_at); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_rcon_wrap;
        run_collect(C_K1, -1, 0, 1'b0, 1'b0);
        checks++; if (got_key[8] !== C_K1_R8) begin errors++; $display("FAIL rcon_r8 got %h exp %h", got_key[8], C_K1_R8); end
        checks++; if (got_key[9] !== C_K1_R9) begin errors++; $display("FAIL rcon_r9 got %h exp %h", got_key[9], C_K1_R9); end
        checks++; if (got_key[10] !== C_K1_R10) begin errors++; $display("FAIL rcon_r10 got %h exp %h", got_key[10], C_K1_R10); end
    endtask

    task automatic test_backpressure;
        run_collect(C_K1, 3, 7, 1'b0, 1'b0);
        checks++; if (!stall_ok) begin errors++; $display("FAIL bp_stable got unstable exp stable"); end
        checks++; if (got_key[3] !== C_K1_R3) begin errors++; $display("FAIL bp_r3 got %h exp %h", got_key[3], C_K1_R3); end
        checks++; if (got_at[4] != 31) begin errors++; $display("FAIL bp_r4_time got %0d exp 31", got_at[4]); end
        checks++; if (got_at[10] != 67) begin errors++; $display("FAIL bp_r10_time got %0d exp 67", got_at[10]); end
        checks++; if (got_key[10] !== C_K1_R10) begin errors++; $display("FAIL bp_r10 got %h exp %h", got_key[10], C_K1_R10); end
        checks++; if (done_at != 68) begin errors++; $display("FAIL bp_done_time got %0d exp 68", done_at); end
    endtask

    task automatic test_start_ignored;
        run_collect(C_K1, -1, 0, 1'b1, 1'b1);
        checks++; if (got_key[5] !== C_K1_R5) begin errors++; $display("FAIL ign_r5 got %h exp %h", got_key[5], C_K1_R5); end
        checks++; if (got_key[10] !== C_K1_R10 || got_at[10] != 60) begin errors++; $display("FAIL ign_r10 got %h@%0d exp %h@60", got_key[10], got_at[10], C_K1_R10); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", done_cnt); end
        checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_done_start got valid=%b busy=%b exp 0 0", rk_valid, busy); end
        run_collect(C_K2, -1, 0, 1'b0, 1'b0);
        checks++; if (got_key[0] !== C_K2) begin errors++; $display("FAIL second_r0 got %h exp %h", got_key[0], C_K2); end
        checks++; if (got_key[10] !== C_K2_R10) begin errors++; $display("FAIL second_r10 got %h exp %h", got_key[10], C_K2_R10); end
    endtask

    task automatic test_midrun_reset;
        @(negedge clk);
        key_in   = C_K1;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (27) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (round_key !== 128'h0 || round_idx !== 4'd0) begin errors++; $display("FAIL mid_reset_key got %h/%0d exp 0/0", round_key, round_idx); end
        checks++; if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got v=%b b=%b d=%b exp 0 0 0", rk_valid, busy, done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_abort got v=%b b=%b exp 0 0", rk_valid, busy); end
        run_collect(C_K2, -1, 0, 1'b0, 1'b0);
        checks++; if (got_key[0] !== C_K2 || got_at[0] != 0) begin errors++; $display("FAIL mid_reset_r0 got %h@%0d exp %h@0", got_key[0], got_at[0], C_K2); end
        checks++; if (got_key[10] !== C_K2_R10) begin errors++; $display("FAIL mid_reset_r10 got %h exp %h", got_key[10], C_K2_R10); end
    endtask

    task automatic test_zero_key;
        run_collect(128'h0, -1, 0, 1'b0, 1'b0);
        checks++; if (got_key[0] !== 128'h0) begin errors++; $display("FAIL zero_r0 got %h exp 0", got_key[0]); end
        checks++; if (got_key[1] !== C_Z_R1) begin errors++; $display("FAIL zero_r1 got %h exp %h", got_key[1], C_Z_R1); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
        rst_n    = 1'b0;
        test_reset();
        test_single();
        test_rcon_wrap();
        test_backpressure();
        test_start_ignored();
        test_midrun_reset();
        test_zero_key();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
